// File: rtl/vxe_biu_sram_responder_if.sv
// ----------------------------------------------------------------------------
// vxe_biu_sram_responder_if
//   Switch<->BIU request/response bundle.
//   Requests (AW/AR) carry pop semantics: the responder raises *pop in the
//   cycle it consumes the request. Responses (B/R) carry push semantics: the
//   responder raises *push in the cycle *ready is high and a response is shown.
//   master : switch side (drives requests and ready, observes pops/pushes)
//   slave  : responder side (vxe_biu_sram_responder)
// ----------------------------------------------------------------------------
interface vxe_biu_sram_responder_if;
    logic [5:0]  biu_awcid;
    logic [39:0] biu_awaddr;
    logic [63:0] biu_awdata;
    logic [7:0]  biu_awstrb;
    logic        biu_awvalid;
    logic        biu_awpop;
    logic [5:0]  biu_arcid;
    logic [39:0] biu_araddr;
    logic        biu_arvalid;
    logic        biu_arpop;
    logic [5:0]  biu_bcid;
    logic [1:0]  biu_bresp;
    logic        biu_bready;
    logic        biu_bpush;
    logic [5:0]  biu_rcid;
    logic [63:0] biu_rdata;
    logic [1:0]  biu_rresp;
    logic        biu_rready;
    logic        biu_rpush;

    modport master (
        output biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_awvalid,
        output biu_arcid, biu_araddr, biu_arvalid,
        output biu_bready, biu_rready,
        input  biu_awpop, biu_arpop,
        input  biu_bcid, biu_bresp, biu_bpush,
        input  biu_rcid, biu_rdata, biu_rresp, biu_rpush
    );

    modport slave (
        input  biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_awvalid,
        input  biu_arcid, biu_araddr, biu_arvalid,
        input  biu_bready, biu_rready,
        output biu_awpop, biu_arpop,
        output biu_bcid, biu_bresp, biu_bpush,
        output biu_rcid, biu_rdata, biu_rresp, biu_rpush
    );
endinterface

// File: rtl/vxe_biu_sram_responder.sv
// ----------------------------------------------------------------------------
// vxe_biu_sram_responder
//   BIU-side endpoint backed by a local 64-bit-wide SRAM window.
//   Accepts at most one AW or AR request per cycle (round-robin when both are
//   eligible, gated by per-channel response credits), returns in-order B and R
//   responses through small FIFOs.
// Ports
//   clk : clock
//   rst : asynchronous active-high reset
//   biu : vxe_biu_sram_responder_if.slave (AW/AR requests, B/R responses)
// Configuration
//   VXE_BIU_RESP_BACKPRESSURE_EN : when defined, a 16-bit LFSR blocks request
//   acceptance in cycles where lfsr[1:0] == 2'b00. Undefined: no gating.
// ----------------------------------------------------------------------------
module vxe_biu_sram_responder #(
    parameter logic [39:0] ADDR_BASE  = 40'h0,
    parameter int unsigned AW         = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    vxe_biu_sram_responder_if.slave biu
);
    localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = PW + 1;
    localparam logic [CW-1:0] CredMax  = CW'(FIFO_DEPTH);
    localparam logic [39:0]   WinBytes = 40'(8) << AW;
    localparam int unsigned   Words    = 1 << AW;

    typedef enum logic {ArbWrite, ArbRead} arb_e;

    // DECERR (out of window, including below base) has priority over SLVERR.
    function automatic logic [1:0] decode(input logic [39:0] addr);
        logic [39:0] off;
        off = addr - ADDR_BASE;
        if (addr < ADDR_BASE || off >= WinBytes) return 2'b11;
        if (addr[2:0] != 3'b000) return 2'b10;
        return 2'b00;
    endfunction

    logic [63:0]   mem [Words];
    arb_e          arb_q, arb_d;
    logic [CW-1:0] b_cred_q, b_cred_d, r_cred_q, r_cred_d;
    logic          accept_en, aw_elig, ar_elig, aw_pop, ar_pop;
    logic [1:0]    aw_resp, ar_resp;
    logic [AW-1:0] aw_word, ar_word;

    // Read pipeline stage: SRAM output is valid the cycle after the pop.
    logic          rd_vld_q;
    logic [5:0]    rd_cid_q;
    logic [1:0]    rd_resp_q;
    logic [63:0]   rd_data_q;

    // Response FIFOs: B entry {cid, resp}, R entry {cid, resp, data}.
    logic [7:0]    b_fifo [FIFO_DEPTH];
    logic [71:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] b_wp_q, b_wp_d, b_rp_q, b_rp_d, r_wp_q, r_wp_d, r_rp_q, r_rp_d;
    logic [CW-1:0] b_cnt_q, b_cnt_d, r_cnt_q, r_cnt_d;
    logic          b_push, r_push, r_enq;
    logic [7:0]    b_head;
    logic [71:0]   r_head;

`ifdef VXE_BIU_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`endif

    // Request arbitration and decode.
    always_comb begin
`ifdef VXE_BIU_RESP_BACKPRESSURE_EN
        accept_en = !rst && (lfsr_q[1:0] != 2'b00);
`else
        accept_en = !rst;
`endif
        aw_elig = accept_en && biu.biu_awvalid && (b_cred_q != '0);
        ar_elig = accept_en && biu.biu_arvalid && (r_cred_q != '0);
        aw_pop  = aw_elig && (!ar_elig || arb_q == ArbWrite);
        ar_pop  = ar_elig && (!aw_elig || arb_q == ArbRead);
        arb_d   = arb_q;
        if (aw_pop)      arb_d = ArbRead;
        else if (ar_pop) arb_d = ArbWrite;
        aw_resp = decode(biu.biu_awaddr);
        ar_resp = decode(biu.biu_araddr);
        aw_word = AW'((biu.biu_awaddr - ADDR_BASE) >> 3);
        ar_word = AW'((biu.biu_araddr - ADDR_BASE) >> 3);
        biu.biu_awpop = aw_pop;
        biu.biu_arpop = ar_pop;
    end

    // Credits track free response slots including reads still in the pipeline.
    always_comb begin
        b_push   = (b_cnt_q != '0) && biu.biu_bready;
        r_push   = (r_cnt_q != '0) && biu.biu_rready;
        r_enq    = rd_vld_q;
        b_wp_d   = aw_pop ? b_wp_q + PW'(1) : b_wp_q;
        b_rp_d   = b_push ? b_rp_q + PW'(1) : b_rp_q;
        r_wp_d   = r_enq  ? r_wp_q + PW'(1) : r_wp_q;
        r_rp_d   = r_push ? r_rp_q + PW'(1) : r_rp_q;
        b_cnt_d  = b_cnt_q + CW'(aw_pop) - CW'(b_push);
        r_cnt_d  = r_cnt_q + CW'(r_enq) - CW'(r_push);
        b_cred_d = b_cred_q - CW'(aw_pop) + CW'(b_push);
        r_cred_d = r_cred_q - CW'(ar_pop) + CW'(r_push);
    end

    // Response outputs show the FIFO head, zero when empty.
    always_comb begin
        b_head         = b_fifo[b_rp_q];
        r_head         = r_fifo[r_rp_q];
        biu.biu_bpush  = b_push;
        biu.biu_rpush  = r_push;
        biu.biu_bcid   = '0;
        biu.biu_bresp  = '0;
        biu.biu_rcid   = '0;
        biu.biu_rresp  = '0;
        biu.biu_rdata  = '0;
        if (b_cnt_q != '0) begin
            biu.biu_bcid  = b_head[7:2];
            biu.biu_bresp = b_head[1:0];
        end
        if (r_cnt_q != '0) begin
            biu.biu_rcid  = r_head[71:66];
            biu.biu_rresp = r_head[65:64];
            biu.biu_rdata = r_head[63:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_q     <= ArbWrite;
            b_cred_q  <= CredMax;
            r_cred_q  <= CredMax;
            b_wp_q    <= '0;
            b_rp_q    <= '0;
            r_wp_q    <= '0;
            r_rp_q    <= '0;
            b_cnt_q   <= '0;
            r_cnt_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_cid_q  <= '0;
            rd_resp_q <= '0;
        end else begin
            arb_q     <= arb_d;
            b_cred_q  <= b_cred_d;
            r_cred_q  <= r_cred_d;
            b_wp_q    <= b_wp_d;
            b_rp_q    <= b_rp_d;
            r_wp_q    <= r_wp_d;
            r_rp_q    <= r_rp_d;
            b_cnt_q   <= b_cnt_d;
            r_cnt_q   <= r_cnt_d;
            rd_vld_q  <= ar_pop;
            rd_cid_q  <= biu.biu_arcid;
            rd_resp_q <= ar_resp;
        end
    end

    // SRAM and FIFO storage carry no reset; validity lives in the counters above.
    always_ff @(posedge clk) begin
        if (aw_pop && aw_resp == 2'b00) begin
            for (int i = 0; i < 8; i++) begin
                if (biu.biu_awstrb[i]) mem[aw_word][i*8 +: 8] <= biu.biu_awdata[i*8 +: 8];
            end
        end
        if (ar_pop) rd_data_q <= mem[ar_word];
        if (aw_pop) b_fifo[b_wp_q] <= {biu.biu_awcid, aw_resp};
        if (r_enq)  r_fifo[r_wp_q] <= {rd_cid_q, rd_resp_q,
                                       (rd_resp_q == 2'b00) ? rd_data_q : 64'h0};
    end
endmodule

// File: tb/tb_vxe_biu_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_vxe_biu_sram_responder
//   Directed bench for vxe_biu_sram_responder: reset, write/read data path,
//   error decode, response-FIFO full behaviour, arbitration and (when
//   VXE_BIU_RESP_BACKPRESSURE_EN is defined) acceptance gating.
// ----------------------------------------------------------------------------
module tb_vxe_biu_sram_responder;
    localparam logic [39:0] Base     = 40'h00_0010_0000;
    localparam int unsigned AwBits   = 4;
    localparam logic [39:0] WinBytes = 40'(8) << AwBits;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pops, idx, bcnt, rcnt, grants;
    logic popped;

    vxe_biu_sram_responder_if bus ();

    vxe_biu_sram_responder #(
        .ADDR_BASE  (Base),
        .AW         (AwBits),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .biu (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input logic [5:0] cid, input logic [39:0] addr,
                          input logic [63:0] data, input logic [7:0] strb);
        bus.biu_awcid  = cid;
        bus.biu_awaddr = addr;
        bus.biu_awdata = data;
        bus.biu_awstrb = strb;
    endtask

    // Returns one #1 into the cycle after the pop.
    task automatic send_aw(input logic [5:0] cid, input logic [39:0] addr,
                           input logic [63:0] data, input logic [7:0] strb);
        int n;
        set_aw(cid, addr, data, strb);
        bus.biu_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.biu_awpop !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("aw_pop_seen", bus.biu_awpop, 1);
        @(posedge clk);
        #1 bus.biu_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] cid, input logic [39:0] addr);
        int n;
        bus.biu_arcid   = cid;
        bus.biu_araddr  = addr;
        bus.biu_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.biu_arpop !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ar_pop_seen", bus.biu_arpop, 1);
        @(posedge clk);
        #1 bus.biu_arvalid = 1'b0;
    endtask

    // Called right after send_aw; a B response is due in the very next cycle.
    task automatic expect_b(input string tag, input logic [5:0] cid, input logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.biu_bpush !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 0);
        check_eq({tag, "_bcid"}, bus.biu_bcid, cid);
        check_eq({tag, "_bresp"}, bus.biu_bresp, resp);
        @(posedge clk);
        #1;
    endtask

    // Called right after send_ar; R response is due two cycles after the pop.
    task automatic expect_r(input string tag, input logic [5:0] cid, input logic [1:0] resp,
                            input logic [63:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.biu_rpush !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 1);
        check_eq({tag, "_rcid"}, bus.biu_rcid, cid);
        check_eq({tag, "_rresp"}, bus.biu_rresp, resp);
        check_eq({tag, "_rdata"}, bus.biu_rdata, data);
        @(posedge clk);
        #1;
    endtask

`ifdef VXE_BIU_RESP_BACKPRESSURE_EN
    logic [15:0] m_lfsr;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(negedge clk) begin
        if (!rst && m_lfsr[1:0] == 2'b00 && (bus.biu_awvalid || bus.biu_arvalid))
            check_eq("bp_gate", {62'b0, bus.biu_awpop, bus.biu_arpop}, 0);
    end
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.biu_awvalid = 1'b0;
        bus.biu_arvalid = 1'b0;
        bus.biu_bready  = 1'b0;
        bus.biu_rready  = 1'b0;
        bus.biu_arcid   = '0;
        bus.biu_araddr  = '0;
        set_aw(6'd0, 40'd0, 64'd0, 8'd0);

        // 1: reset state, then first-cycle acceptance
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pops", {bus.biu_awpop, bus.biu_arpop, bus.biu_bpush, bus.biu_rpush}, 0);
        check_eq("rst_b", {bus.biu_bcid, bus.biu_bresp}, 0);
        check_eq("rst_r", {bus.biu_rcid, bus.biu_rresp}, 0);
        check_eq("rst_rdata", bus.biu_rdata, 0);
        set_aw(6'd5, Base, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        bus.biu_awvalid = 1'b1;
        bus.biu_bready  = 1'b1;
        bus.biu_rready  = 1'b1;
        @(negedge clk);
        check_eq("rst_hold_awpop", bus.biu_awpop, 0);
        rst = 1'b0;
        #1;
        check_eq("t1_first_pop", bus.biu_awpop, 1);
        @(posedge clk);
        #1 bus.biu_awvalid = 1'b0;
        expect_b("t1", 6'd5, 2'b00);

        // 2: partial-strobe writes and read-back
        send_aw(6'd7, Base + 40'd8, 64'h0, 8'hFF);
        expect_b("t2_clr", 6'd7, 2'b00);
        send_aw(6'd7, Base + 40'd8, 64'h1122_3344_5566_7788, 8'h0F);
        expect_b("t2_wr_lo", 6'd7, 2'b00);
        send_ar(6'd9, Base + 40'd8);
        expect_r("t2_rd_lo", 6'd9, 2'b00, 64'h0000_0000_5566_7788);
        send_aw(6'd8, Base + 40'd8, 64'hAABB_CCDD_EEFF_0011, 8'hF0);
        expect_b("t2_wr_hi", 6'd8, 2'b00);
        send_ar(6'd10, Base + 40'd8);
        expect_r("t2_rd_hi", 6'd10, 2'b00, 64'hAABB_CCDD_5566_7788);

        // 3: error decode, SRAM left untouched
        send_ar(6'd3, Base + 40'd3);
        expect_r("t3_slverr", 6'd3, 2'b10, 64'h0);
        send_ar(6'd4, Base - 40'd8);
        expect_r("t3_below", 6'd4, 2'b11, 64'h0);
        send_ar(6'd6, Base + WinBytes + 40'd3);
        expect_r("t3_dec_wins", 6'd6, 2'b11, 64'h0);
        send_aw(6'd11, Base + WinBytes, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        expect_b("t3_wr_dec", 6'd11, 2'b11);
        send_aw(6'd12, Base + 40'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        expect_b("t3_wr_slv", 6'd12, 2'b10);
        send_ar(6'd13, Base);
        expect_r("t3_word0", 6'd13, 2'b00, 64'hDEAD_BEEF_0000_0001);
        send_ar(6'd14, Base + 40'd8);
        expect_r("t3_word1", 6'd14, 2'b00, 64'hAABB_CCDD_5566_7788);

        // 4: B FIFO full, then drain in order while the rest are accepted
        bus.biu_bready = 1'b0;
        idx  = 0;
        pops = 0;
        set_aw(6'd10, Base + 40'd16, 64'h1000, 8'hFF);
        bus.biu_awvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            popped = bus.biu_awpop;
            if (popped) pops++;
            @(posedge clk);
            #1;
            if (popped) begin
                idx++;
                if (idx < 6) set_aw(6'(10 + idx), Base + 40'd16 + 40'(8 * idx),
                                    64'h1000 + 64'(idx), 8'hFF);
                else bus.biu_awvalid = 1'b0;
            end
        end
        check_eq("t4_pops_full", 64'(pops), 4);
        check_eq("t4_stall", {bus.biu_awpop, bus.biu_bpush}, 0);
        bus.biu_bready = 1'b1;
        bcnt = 0;
        for (int c = 0; c < 60 && bcnt < 6; c++) begin
            @(negedge clk);
            popped = bus.biu_awpop;
            if (popped) pops++;
            if (bus.biu_bpush) begin
                check_eq($sformatf("t4_bcid%0d", bcnt), bus.biu_bcid, 64'(10 + bcnt));
                bcnt++;
            end
            @(posedge clk);
            #1;
            if (popped) begin
                idx++;
                if (idx < 6) set_aw(6'(10 + idx), Base + 40'd16 + 40'(8 * idx),
                                    64'h1000 + 64'(idx), 8'hFF);
                else bus.biu_awvalid = 1'b0;
            end
        end
        check_eq("t4_bcnt", 64'(bcnt), 6);
        check_eq("t4_pops_all", 64'(pops), 6);
        send_ar(6'd20, Base + 40'd56);
        expect_r("t4_rd_last", 6'd20, 2'b00, 64'h1005);

        // 5: arbitration after reset starts on AW and alternates
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_aw(6'd30, Base + 40'd64, 64'h0, 8'h00);
        bus.biu_arcid   = 6'd31;
        bus.biu_araddr  = Base + 40'd8;
        bus.biu_awvalid = 1'b1;
        bus.biu_arvalid = 1'b1;
        grants = 0;
        bcnt   = 0;
        rcnt   = 0;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            @(negedge clk);
            if (bus.biu_bpush) bcnt++;
            if (bus.biu_rpush) begin
                if (rcnt == 0) check_eq("t5_rdata", bus.biu_rdata, 64'hAABB_CCDD_5566_7788);
                rcnt++;
            end
            if (bus.biu_awpop || bus.biu_arpop) begin
                check_eq($sformatf("t5_grant%0d", grants), {bus.biu_awpop, bus.biu_arpop},
                         (grants % 2 == 0) ? 64'd2 : 64'd1);
                grants++;
            end
            @(posedge clk);
            #1;
        end
        bus.biu_awvalid = 1'b0;
        bus.biu_arvalid = 1'b0;
        check_eq("t5_grants", 64'(grants), 8);
        repeat (6) begin
            @(negedge clk);
            if (bus.biu_bpush) bcnt++;
            if (bus.biu_rpush) rcnt++;
            @(posedge clk);
            #1;
        end
        check_eq("t5_bcnt", 64'(bcnt), 4);
        check_eq("t5_rcnt", 64'(rcnt), 4);
        check_eq("t5_idle_rdata", bus.biu_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
